// File: rtl/cnn_mul_share_arb_if.sv
// Bundle between the conv1 lane controllers (master) and the shared-multiplier arbiter (slave).
// Handshake: an op transfers in any cycle where req_valid[i] & req_ready[i]; req_ready is a
// combinational function of req_valid, so requesters must never derive req_valid from req_ready.
interface cnn_mul_share_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 9,
    parameter int DIN1_WIDTH = 14,
    parameter int DOUT_WIDTH = 23,
    parameter int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0;
    logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DOUT_WIDTH-1:0]         rsp_dout;
    logic                          busy;
    logic [PTR_W-1:0]              dbg_ptr;

    modport master (
        output req_valid, req_din0, req_din1,
        input  req_ready, rsp_valid, rsp_dout, busy, dbg_ptr
    );

    modport slave (
        input  req_valid, req_din0, req_din1,
        output req_ready, rsp_valid, rsp_dout, busy, dbg_ptr
    );
endinterface

// File: rtl/cnn_mul_share_arb.sv
// Round-robin arbiter time-sharing one signed DIN0 x DIN1 multiplier among NUM_REQ requesters,
// returning each product MUL_STAGES cycles after acceptance with a one-hot requester tag.
module cnn_mul_share_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DIN0_WIDTH = 9,
    parameter int DIN1_WIDTH = 14,
    parameter int DOUT_WIDTH = 23,   // must equal DIN0_WIDTH + DIN1_WIDTH
    parameter int MUL_STAGES = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    cnn_mul_share_arb_if.slave    bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [NUM_REQ-1:0]           grant;
    logic                         hs;
    logic [PTR_W-1:0]             gidx;
    logic signed [DIN0_WIDTH-1:0] sel_a, a_q;
    logic signed [DIN1_WIDTH-1:0] sel_b, b_q;
    logic [MUL_STAGES-1:0]        v_q;
    logic [NUM_REQ-1:0]           tag_q [MUL_STAGES];
    logic signed [DOUT_WIDTH-1:0] prod;
    logic signed [DOUT_WIDTH-1:0] dout;

    // Pass 0 scans ptr..NUM_REQ-1, pass 1 wraps to 0..ptr-1; first valid wins.
    always_comb begin
        grant = '0;
        hs    = 1'b0;
        gidx  = '0;
        sel_a = '0;
        sel_b = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!hs && bus.req_valid[i] &&
                    ((p == 0) ? (i >= int'(ptr_q)) : (i < int'(ptr_q)))) begin
                    grant[i] = 1'b1;
                    hs       = 1'b1;
                    gidx     = PTR_W'(i);
                    sel_a    = bus.req_din0[i*DIN0_WIDTH +: DIN0_WIDTH];
                    sel_b    = bus.req_din1[i*DIN1_WIDTH +: DIN1_WIDTH];
                end
            end
        end
        if (!ap_rst_n) begin
            grant = '0;
            hs    = 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    // Operand registers load only on acceptance so the product (and rsp_dout) holds when idle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            v_q   <= '0;
            for (int s = 0; s < MUL_STAGES; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            v_q[0]   <= hs;
            tag_q[0] <= grant;
            if (hs) begin
                a_q <= sel_a;
                b_q <= sel_b;
            end
            for (int s = 1; s < MUL_STAGES; s++) begin
                v_q[s]   <= v_q[s-1];
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign prod = a_q * b_q;

    generate
        if (MUL_STAGES == 1) begin : g_one
            assign dout = prod;
        end else begin : g_multi
            logic signed [DOUT_WIDTH-1:0] prod_q [MUL_STAGES-1];

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int s = 0; s < MUL_STAGES - 1; s++) begin
                        prod_q[s] <= '0;
                    end
                end else begin
                    if (v_q[0]) begin
                        prod_q[0] <= prod;
                    end
                    for (int s = 1; s < MUL_STAGES - 1; s++) begin
                        if (v_q[s]) begin
                            prod_q[s] <= prod_q[s-1];
                        end
                    end
                end
            end

            assign dout = prod_q[MUL_STAGES-2];
        end
    endgenerate

    assign bus.req_ready = grant;
    assign bus.rsp_valid = v_q[MUL_STAGES-1] ? tag_q[MUL_STAGES-1] : '0;
    assign bus.rsp_dout  = dout;
    assign bus.busy      = |v_q;
    assign bus.dbg_ptr   = ptr_q;
endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// Bench for cnn_mul_share_arb: directed literal scenarios plus randomized traffic checked every
// cycle against a queue-based model of round-robin grants and fixed-latency in-order results.
module tb_cnn_mul_share_arb;
    localparam int NR = 4;
    localparam int W0 = 9;
    localparam int W1 = 14;
    localparam int WO = 23;
    localparam int MS = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cnn_mul_share_arb_if #(.NUM_REQ(NR), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO)) bus ();

    cnn_mul_share_arb #(
        .NUM_REQ(NR), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO), .MUL_STAGES(MS)
    ) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: expected results queue, each due MS cycles after its handshake.
    typedef struct {
        int     due;
        int     tag;
        longint prod;
    } rsp_t;
    rsp_t   exp_q[$];
    int     m_ptr = 0;
    longint last_dout = 0;
    int     cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ready", longint'(bus.req_ready), 0);
            check("rst_rsp_valid", longint'(bus.rsp_valid), 0);
            check("rst_busy", longint'(bus.busy), 0);
            check("rst_dout", longint'($signed(bus.rsp_dout)), 0);
            exp_q.delete();
            m_ptr = 0;
            last_dout = 0;
        end else begin
            int g;
            g = -1;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (g < 0 && bus.req_valid[i]) g = i;
            end
            check("req_ready", longint'(bus.req_ready), (g < 0) ? 0 : (longint'(1) << g));
            check("ptr", longint'(bus.dbg_ptr), m_ptr);
            check("busy", longint'(bus.busy), (exp_q.size() > 0) ? 1 : 0);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("rsp_valid", longint'(bus.rsp_valid), longint'(1) << exp_q[0].tag);
                check("rsp_dout", longint'($signed(bus.rsp_dout)), exp_q[0].prod);
                last_dout = exp_q[0].prod;
                void'(exp_q.pop_front());
            end else begin
                check("rsp_idle", longint'(bus.rsp_valid), 0);
                check("rsp_hold", longint'($signed(bus.rsp_dout)), last_dout);
            end
            if (g >= 0) begin
                longint p;
                p = longint'($signed(bus.req_din0[g*W0 +: W0])) *
                    longint'($signed(bus.req_din1[g*W1 +: W1]));
                exp_q.push_back('{cyc + MS, g, p});
                m_ptr = (g + 1) % NR;
            end
        end
    end

    // Requester-side state
    logic signed [W0-1:0] op_a [NR];
    logic signed [W1-1:0] op_b [NR];
    logic [NR-1:0]        pend;

    task automatic step(input logic [NR-1:0] v);
        @(posedge clk);
        #1;
        bus.req_valid = v;
        for (int i = 0; i < NR; i++) begin
            bus.req_din0[i*W0 +: W0] = op_a[i];
            bus.req_din1[i*W1 +: W1] = op_b[i];
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("reset_busy", longint'(bus.busy), 0);
            check("reset_rsp_valid", longint'(bus.rsp_valid), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic new_op(input int i);
        op_a[i] = W0'($urandom);
        op_b[i] = W1'($urandom);
        if ($urandom_range(0, 7) == 0) op_a[i] = $urandom_range(0, 1) ? 9'h0FF : 9'h100;
        if ($urandom_range(0, 7) == 0) op_b[i] = $urandom_range(0, 1) ? 14'h1FFF : 14'h2000;
    endtask

    initial begin
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.req_din0 = '0;
        bus.req_din1 = '0;
        for (int i = 0; i < NR; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        pend = '0;
        #1;
        do_reset();

        // Single requester, -3 * 100
        op_a[0] = -9'sd3;
        op_b[0] = 14'sd100;
        step(4'b0001);
        check("t1_grant", longint'(bus.req_ready), 1);
        step(4'b0000);
        step(4'b0000);
        check("t1_rsp_valid", longint'(bus.rsp_valid), 1);
        check("t1_rsp_dout", longint'($signed(bus.rsp_dout)), -300);

        // All four valid from ptr=0: strict rotation
        do_reset();
        for (int i = 0; i < NR; i++) new_op(i);
        for (int k = 0; k < 10; k++) begin
            step((k < 8) ? 4'b1111 : 4'b0000);
            if (k < 8) check("t2_grant", longint'(bus.req_ready), longint'(1) << (k % 4));
            if (k >= 2) check("t2_rsp", longint'(bus.rsp_valid), longint'(1) << ((k - 2) % 4));
        end

        // req1 and req3 only: idle req2 skipped
        step(4'b1010);
        check("t3_grant_a", longint'(bus.req_ready), 2);
        step(4'b1010);
        check("t3_grant_b", longint'(bus.req_ready), 8);
        step(4'b1010);
        check("t3_grant_c", longint'(bus.req_ready), 2);
        repeat (3) step(4'b0000);

        // Extreme operands
        op_a[0] = 9'h100; op_b[0] = 14'h2000;
        step(4'b0001); step(4'b0000); step(4'b0000);
        check("t4_minmin", longint'($signed(bus.rsp_dout)), 2097152);
        op_a[0] = 9'h0FF; op_b[0] = 14'h1FFF;
        step(4'b0001); step(4'b0000); step(4'b0000);
        check("t4_maxmax", longint'($signed(bus.rsp_dout)), 2088705);
        op_a[0] = 9'h100; op_b[0] = 14'h1FFF;
        step(4'b0001); step(4'b0000); step(4'b0000);
        check("t4_minmax", longint'($signed(bus.rsp_dout)), -2096896);

        // Reset with two ops in flight
        step(4'b0011);
        step(4'b0011);
        do_reset();
        repeat (3) begin
            step(4'b0000);
            check("t5_no_rsp", longint'(bus.rsp_valid), 0);
            check("t5_not_busy", longint'(bus.busy), 0);
        end
        step(4'b1111);
        check("t5_grant_req0", longint'(bus.req_ready), 1);
        repeat (3) step(4'b0000);

        // Randomized traffic
        begin
            int density;
            logic [NR-1:0] v;
            density = 2;
            for (int c = 0; c < 10000; c++) begin
                if (c % 500 == 0) density = $urandom_range(0, 3);
                for (int i = 0; i < NR; i++) begin
                    if (!pend[i] && $urandom_range(0, 3) < density) begin
                        pend[i] = 1'b1;
                        new_op(i);
                    end
                end
                for (int i = 0; i < NR; i++) v[i] = pend[i] && ($urandom_range(0, 7) != 0);
                step(v);
                pend = pend & ~(bus.req_ready & v);
            end
        end
        repeat (MS + 3) step(4'b0000);
        check("drain_empty", longint'(exp_q.size()), 0);
        check("drain_busy", longint'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
